rvsteel_bus_arbiter: RTL and testbench
======================================

# rvsteel_bus_arbiter

Two-master, one-slave arbiter for the single-cycle-response register bus used by the GPIO, UART and timer peripherals. It lets a second requester share one peripheral port with the CPU, for example a pattern sequencer driving GPIO SET/CLR. It grants masters round-robin, forwards one transaction at a time to the slave, and returns the response and read data only to the granted master.

## Interface
- ADDR_WIDTH, 5, width of rw_address on all ports.
- TIMEOUT_CYCLES, 15, cycles to wait for a slave response before aborting. Used only with the timeout feature.

- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mN_rw_address  in  ADDR_WIDTH  master N address, N = 0 or 1.
- mN_read_request / mN_write_request  in  1  master N requests. Held until the matching response.
- mN_write_data  in  32  master N write data.
- mN_write_strobe  in  4  master N byte strobes.
- mN_read_data  out  32  read data. Valid only with mN_read_response; 0 otherwise.
- mN_read_response / mN_write_response  out  1  one-cycle completion pulses.
- s_rw_address  out  ADDR_WIDTH  address to the slave.
- s_read_request / s_write_request  out  1  requests to the slave.
- s_write_data  out  32  write data to the slave.
- s_write_strobe  out  4  byte strobes to the slave.
- s_read_data  in  32  slave read data.
- s_read_response / s_write_response  in  1  slave response pulses.
- bus_error  out  1  sticky timeout flag.

## Operation
- States:
  - IDLE: sample requests.
  - ISSUE: slave request asserted for one cycle.
  - WAIT: await the slave response.
- IDLE:
  - Master N is pending when mN_read_request | mN_write_request.
  - Only one master pending: grant it.
  - Both pending: grant the master other than last_grant.
  - On grant: register the granted master's address, data, strobe and request bits into the s_* registers, set last_grant, go to ISSUE.
- ISSUE: s_* requests are high for this cycle only; next state is WAIT. The s_* address, data and strobe hold their values until the next grant.
- WAIT:
  - s_read_response and s_write_response pass combinationally to the granted master's matching response.
  - s_read_data passes to the granted master's mN_read_data in the same cycle.
  - Any slave response returns the state to IDLE.
- Both read and write requested together: both are forwarded. The transaction completes on the first cycle with either response; each response that arrives in that cycle is passed through.
- The non-granted master sees response 0 and read_data 0 at all times.
- A master that drops its request during ISSUE or WAIT still gets its response pulse. The slave transaction is never cancelled.
- Slave responses seen in IDLE or ISSUE are ignored, not forwarded.
- Reset values: all outputs 0, state IDLE, last_grant = m1 (so m0 wins the first tie), bus_error 0, timeout counter 0.
- Reset mid-transaction: the FSM goes to IDLE immediately. No response is issued for the aborted transaction.

## Timing
- Master request seen in IDLE at cycle T:
  - s_*_request high in T+1.
  - With a single-cycle slave, the master response arrives in T+2.
  - FSM is back in IDLE at T+3.
- Throughput is one transaction per 3 cycles with single-cycle slaves.
- A master must deassert its request in the cycle after its response unless it is issuing a new transaction. A request high in IDLE is always a new transaction.
- Response and read_data paths are combinational from slave to master. All request paths to the slave are registered.

## Configuration
- RVSTEEL_BUS_ARBITER_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If no slave response arrives after TIMEOUT_CYCLES cycles in WAIT, the arbiter pulses the granted master's response for each requested type, with read_data = 32'h0.
  - It then sets bus_error (cleared only by reset) and returns to IDLE.
  - A slave response arriving later is ignored.
- Not defined: WAIT lasts until the slave responds, with no bound; the counter is absent and bus_error is tied 0.

## Test plan
- m0 read of address 0x04 only; slave returns 32'h3 in the cycle after its request:
  - s_read_request high in T+1 only.
  - m0_read_response and m0_read_data = 3 in T+2.
  - m1 outputs stay 0.
- m0 and m1 both write from reset, m0 data 1 at 0x08, m1 data 2 at 0x10:
  - m0 is served first; m1's s_write_request rises 3 cycles after m0's.
  - Both masters held high continuously: grants alternate m0, m1, m0.
- m1 read and write together, single-cycle slave:
  - Both s requests high in the same cycle.
  - Both m1 responses pulse in the same cycle.
- Slave responds 4 cycles late:
  - The response is forwarded in its arrival cycle.
  - No second s request is issued while in WAIT.
- reset asserted during WAIT: all outputs 0 in the next cycle; a slave response then arriving is not forwarded.
- With the timeout macro and a slave that never responds:
  - The master gets its response TIMEOUT_CYCLES cycles after entering WAIT, with read_data 0.
  - bus_error = 1 and stays high until reset.

Source files
------------

// File: rtl/rvsteel_bus_arbiter.sv
// Two-master round-robin arbiter for the single-cycle-response register bus.
// Optional response timeout: define RVSTEEL_BUS_ARBITER_TIMEOUT_EN.
module rvsteel_bus_arbiter #(
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_rw_address,
    input  logic                  m0_read_request,
    input  logic                  m0_write_request,
    input  logic [31:0]           m0_write_data,
    input  logic [3:0]            m0_write_strobe,
    output logic [31:0]           m0_read_data,
    output logic                  m0_read_response,
    output logic                  m0_write_response,

    input  logic [ADDR_WIDTH-1:0] m1_rw_address,
    input  logic                  m1_read_request,
    input  logic                  m1_write_request,
    input  logic [31:0]           m1_write_data,
    input  logic [3:0]            m1_write_strobe,
    output logic [31:0]           m1_read_data,
    output logic                  m1_read_response,
    output logic                  m1_write_response,

    output logic [ADDR_WIDTH-1:0] s_rw_address,
    output logic                  s_read_request,
    output logic                  s_write_request,
    output logic [31:0]           s_write_data,
    output logic [3:0]            s_write_strobe,
    input  logic [31:0]           s_read_data,
    input  logic                  s_read_response,
    input  logic                  s_write_response,

    output logic                  bus_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  rreq_q, rreq_d;
    logic                  wreq_q, wreq_d;

    logic                  m0_pend;
    logic                  m1_pend;
    logic                  sel;
    logic                  in_wait;
    logic                  slave_done;
    logic                  timeout_hit;
    logic                  to_rd;
    logic                  to_wr;
    logic                  fwd_rd;
    logic                  fwd_wr;
    logic [31:0]           fwd_rdata;

    assign m0_pend    = m0_read_request | m0_write_request;
    assign m1_pend    = m1_read_request | m1_write_request;
    assign in_wait    = (state_q == ST_WAIT);
    assign slave_done = in_wait & (s_read_response | s_write_response);

`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          txn_rd_q, txn_rd_d;
    logic          txn_wr_q, txn_wr_d;
    logic          bus_error_q, bus_error_d;

    // Abort only when the slave stays silent for the full budget.
    assign timeout_hit = in_wait & ~slave_done & (cnt_q == CW'(TIMEOUT_CYCLES));
    assign to_rd       = timeout_hit & txn_rd_q;
    assign to_wr       = timeout_hit & txn_wr_q;
    assign bus_error   = bus_error_q;

    // Wait counter, latched request types and sticky error flag.
    always_comb begin
        cnt_d       = '0;
        txn_rd_d    = txn_rd_q;
        txn_wr_d    = txn_wr_q;
        bus_error_d = bus_error_q | timeout_hit;
        if (state_q == ST_ISSUE) begin
            txn_rd_d = rreq_q;
            txn_wr_d = wreq_q;
        end
        if (in_wait & ~slave_done & ~timeout_hit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Timeout state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            txn_rd_q    <= 1'b0;
            txn_wr_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            txn_rd_q    <= txn_rd_d;
            txn_wr_q    <= txn_wr_d;
            bus_error_q <= bus_error_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign to_rd       = 1'b0;
    assign to_wr       = 1'b0;
    assign bus_error   = 1'b0;
`endif

    // Arbitration and transaction sequencing.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rreq_d  = 1'b0;
        wreq_d  = 1'b0;
        sel     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (m0_pend | m1_pend) begin
                    // On a tie the master that did not go last wins.
                    sel     = (m0_pend & m1_pend) ? ~grant_q : m1_pend;
                    grant_d = sel;
                    addr_d  = sel ? m1_rw_address    : m0_rw_address;
                    wdata_d = sel ? m1_write_data    : m0_write_data;
                    wstrb_d = sel ? m1_write_strobe  : m0_write_strobe;
                    rreq_d  = sel ? m1_read_request  : m0_read_request;
                    wreq_d  = sel ? m1_write_request : m0_write_request;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (slave_done | timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Main state registers; m1 marked as last grant so m0 wins first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rreq_q  <= 1'b0;
            wreq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rreq_q  <= rreq_d;
            wreq_q  <= wreq_d;
        end
    end

    // Slave responses are only honoured while waiting for them.
    always_comb begin
        fwd_rd    = (in_wait & s_read_response) | to_rd;
        fwd_wr    = (in_wait & s_write_response) | to_wr;
        fwd_rdata = (in_wait & s_read_response) ? s_read_data : 32'h0;
    end

    assign m0_read_response  = fwd_rd & ~grant_q;
    assign m0_write_response = fwd_wr & ~grant_q;
    assign m0_read_data      = grant_q ? 32'h0 : fwd_rdata;

    assign m1_read_response  = fwd_rd & grant_q;
    assign m1_write_response = fwd_wr & grant_q;
    assign m1_read_data      = grant_q ? fwd_rdata : 32'h0;

    assign s_rw_address    = addr_q;
    assign s_read_request  = rreq_q;
    assign s_write_request = wreq_q;
    assign s_write_data    = wdata_q;
    assign s_write_strobe  = wstrb_q;

endmodule

// File: tb/tb_rvsteel_bus_arbiter.sv
// Directed self-checking bench for rvsteel_bus_arbiter.
// Timeout scenario runs when RVSTEEL_BUS_ARBITER_TIMEOUT_EN is defined.
module tb_rvsteel_bus_arbiter;

    localparam int AW = 5;
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] m0_rw_address, m1_rw_address, s_rw_address;
    logic          m0_read_request, m0_write_request;
    logic          m1_read_request, m1_write_request;
    logic [31:0]   m0_write_data, m1_write_data, s_write_data;
    logic [3:0]    m0_write_strobe, m1_write_strobe, s_write_strobe;
    logic [31:0]   m0_read_data, m1_read_data, s_read_data;
    logic          m0_read_response, m0_write_response;
    logic          m1_read_response, m1_write_response;
    logic          s_read_request, s_write_request;
    logic          s_read_response, s_write_response;
    logic          bus_error;

    int total = 0;
    int bad   = 0;

    rvsteel_bus_arbiter #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .m0_rw_address     (m0_rw_address),
        .m0_read_request   (m0_read_request),
        .m0_write_request  (m0_write_request),
        .m0_write_data     (m0_write_data),
        .m0_write_strobe   (m0_write_strobe),
        .m0_read_data      (m0_read_data),
        .m0_read_response  (m0_read_response),
        .m0_write_response (m0_write_response),
        .m1_rw_address     (m1_rw_address),
        .m1_read_request   (m1_read_request),
        .m1_write_request  (m1_write_request),
        .m1_write_data     (m1_write_data),
        .m1_write_strobe   (m1_write_strobe),
        .m1_read_data      (m1_read_data),
        .m1_read_response  (m1_read_response),
        .m1_write_response (m1_write_response),
        .s_rw_address      (s_rw_address),
        .s_read_request    (s_read_request),
        .s_write_request   (s_write_request),
        .s_write_data      (s_write_data),
        .s_write_strobe    (s_write_strobe),
        .s_read_data       (s_read_data),
        .s_read_response   (s_read_response),
        .s_write_response  (s_write_response),
        .bus_error         (bus_error)
    );

    always #5 clock = ~clock;

    // Inputs change 1ns after the edge; checks follow 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m0_rw_address    = '0;
        m0_read_request  = 1'b0;
        m0_write_request = 1'b0;
        m0_write_data    = '0;
        m0_write_strobe  = '0;
        m1_rw_address    = '0;
        m1_read_request  = 1'b0;
        m1_write_request = 1'b0;
        m1_write_data    = '0;
        m1_write_strobe  = '0;
        s_read_data      = '0;
        s_read_response  = 1'b0;
        s_write_response = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        #1;
        total++; if (s_read_request !== 1'b0) begin bad++; $display("FAIL rst_s_rreq got=%b exp=0", s_read_request); end
        total++; if (s_write_request !== 1'b0) begin bad++; $display("FAIL rst_s_wreq got=%b exp=0", s_write_request); end
        total++; if (s_rw_address !== 5'h0) begin bad++; $display("FAIL rst_s_addr got=%h exp=0", s_rw_address); end
        total++; if (s_write_data !== 32'h0) begin bad++; $display("FAIL rst_s_wdata got=%h exp=0", s_write_data); end
        total++; if (s_write_strobe !== 4'h0) begin bad++; $display("FAIL rst_s_wstrb got=%h exp=0", s_write_strobe); end
        total++; if ({m0_read_response, m0_write_response, m1_read_response, m1_write_response} !== 4'b0)
            begin bad++; $display("FAIL rst_resps got=%b exp=0000", {m0_read_response, m0_write_response, m1_read_response, m1_write_response}); end
        total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL rst_bus_error got=%b exp=0", bus_error); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_rw_address   = 5'h04;
        m0_read_request = 1'b1;
        #1;
        total++; if (s_read_request !== 1'b0) begin bad++; $display("FAIL rd_T_s_rreq got=%b exp=0", s_read_request); end
        tick();
        #1;
        total++; if (s_read_request !== 1'b1) begin bad++; $display("FAIL rd_T1_s_rreq got=%b exp=1", s_read_request); end
        total++; if (s_write_request !== 1'b0) begin bad++; $display("FAIL rd_T1_s_wreq got=%b exp=0", s_write_request); end
        total++; if (s_rw_address !== 5'h04) begin bad++; $display("FAIL rd_T1_addr got=%h exp=04", s_rw_address); end
        tick();
        s_read_response = 1'b1;
        s_read_data     = 32'h3;
        #1;
        total++; if (s_read_request !== 1'b0) begin bad++; $display("FAIL rd_T2_s_rreq got=%b exp=0", s_read_request); end
        total++; if (m0_read_response !== 1'b1) begin bad++; $display("FAIL rd_T2_m0_rresp got=%b exp=1", m0_read_response); end
        total++; if (m0_read_data !== 32'h3) begin bad++; $display("FAIL rd_T2_m0_rdata got=%h exp=3", m0_read_data); end
        total++; if (m1_read_response !== 1'b0) begin bad++; $display("FAIL rd_T2_m1_rresp got=%b exp=0", m1_read_response); end
        total++; if (m1_read_data !== 32'h0) begin bad++; $display("FAIL rd_T2_m1_rdata got=%h exp=0", m1_read_data); end
        tick();
        s_read_response = 1'b0;
        s_read_data     = 32'h0;
        m0_read_request = 1'b0;
        #1;
        total++; if (m0_read_response !== 1'b0) begin bad++; $display("FAIL rd_T3_m0_rresp got=%b exp=0", m0_read_response); end
        tick();
        #1;
        total++; if (s_read_request !== 1'b0) begin bad++; $display("FAIL rd_T4_no_reissue got=%b exp=0", s_read_request); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_addr [3];
        logic [31:0]   exp_data [3];
        logic [1:0]    exp_wr;
        exp_addr[0] = 5'h08; exp_addr[1] = 5'h10; exp_addr[2] = 5'h08;
        exp_data[0] = 32'h1; exp_data[1] = 32'h2; exp_data[2] = 32'h1;
        do_reset();
        m0_rw_address    = 5'h08;
        m0_write_data    = 32'h1;
        m0_write_strobe  = 4'hf;
        m0_write_request = 1'b1;
        m1_rw_address    = 5'h10;
        m1_write_data    = 32'h2;
        m1_write_strobe  = 4'hf;
        m1_write_request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_wr = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            #1;
            total++; if (s_write_request !== 1'b1 || s_rw_address !== exp_addr[i] || s_write_data !== exp_data[i])
                begin bad++; $display("FAIL rr%0d_issue got=%b/%h/%h exp=1/%h/%h", i, s_write_request, s_rw_address, s_write_data, exp_addr[i], exp_data[i]); end
            tick();
            s_write_response = 1'b1;
            #1;
            total++; if ({m1_write_response, m0_write_response} !== exp_wr)
                begin bad++; $display("FAIL rr%0d_resp got=%b exp=%b", i, {m1_write_response, m0_write_response}, exp_wr); end
            tick();
            s_write_response = 1'b0;
            if (i == 2) begin
                m0_write_request = 1'b0;
                m1_write_request = 1'b0;
            end
            #1;
            total++; if (s_write_request !== 1'b0) begin bad++; $display("FAIL rr%0d_idle got=%b exp=0", i, s_write_request); end
        end
        tick();
    endtask

    task automatic test_read_write_both();
        do_reset();
        m1_rw_address    = 5'h1c;
        m1_write_data    = 32'hdeadbeef;
        m1_write_strobe  = 4'h5;
        m1_read_request  = 1'b1;
        m1_write_request = 1'b1;
        tick();
        #1;
        total++; if ({s_read_request, s_write_request} !== 2'b11) begin bad++; $display("FAIL rw_s_reqs got=%b exp=11", {s_read_request, s_write_request}); end
        total++; if (s_write_strobe !== 4'h5 || s_write_data !== 32'hdeadbeef)
            begin bad++; $display("FAIL rw_s_data got=%h/%h exp=5/deadbeef", s_write_strobe, s_write_data); end
        tick();
        s_read_response  = 1'b1;
        s_write_response = 1'b1;
        s_read_data      = 32'h12345678;
        #1;
        total++; if ({m1_read_response, m1_write_response} !== 2'b11) begin bad++; $display("FAIL rw_m1_resps got=%b exp=11", {m1_read_response, m1_write_response}); end
        total++; if (m1_read_data !== 32'h12345678) begin bad++; $display("FAIL rw_m1_rdata got=%h exp=12345678", m1_read_data); end
        total++; if ({m0_read_response, m0_write_response} !== 2'b00 || m0_read_data !== 32'h0)
            begin bad++; $display("FAIL rw_m0_quiet got=%b/%h exp=00/0", {m0_read_response, m0_write_response}, m0_read_data); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_late_response();
        do_reset();
        m0_rw_address    = 5'h0c;
        m0_write_data    = 32'haa;
        m0_write_strobe  = 4'h1;
        m0_write_request = 1'b1;
        tick();
        s_write_response = 1'b1;
        #1;
        total++; if (m0_write_response !== 1'b0) begin bad++; $display("FAIL late_issue_ignored got=%b exp=0", m0_write_response); end
        for (int k = 0; k < 3; k++) begin
            tick();
            s_write_response = 1'b0;
            #1;
            total++; if (s_write_request !== 1'b0 || m0_write_response !== 1'b0)
                begin bad++; $display("FAIL late_wait%0d got=%b/%b exp=0/0", k, s_write_request, m0_write_response); end
        end
        tick();
        s_write_response = 1'b1;
        #1;
        total++; if (m0_write_response !== 1'b1) begin bad++; $display("FAIL late_fwd got=%b exp=1", m0_write_response); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_rw_address   = 5'h14;
        m0_read_request = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset           = 1'b0;
        m0_read_request = 1'b0;
        s_read_response = 1'b1;
        s_read_data     = 32'hab;
        #1;
        total++; if (m0_read_response !== 1'b0 || m0_read_data !== 32'h0)
            begin bad++; $display("FAIL rstmid_fwd got=%b/%h exp=0/0", m0_read_response, m0_read_data); end
        total++; if (s_read_request !== 1'b0 || s_rw_address !== 5'h0)
            begin bad++; $display("FAIL rstmid_s got=%b/%h exp=0/0", s_read_request, s_rw_address); end
        tick();
        clear_inputs();
        tick();
    endtask

`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        m1_rw_address   = 5'h18;
        m1_read_request = 1'b1;
        tick();
        tick();
        for (int k = 0; k < TO; k++) begin
            #1;
            total++; if (m1_read_response !== 1'b0) begin bad++; $display("FAIL to_early%0d got=%b exp=0", k, m1_read_response); end
            tick();
        end
        #1;
        total++; if (m1_read_response !== 1'b1 || m1_read_data !== 32'h0)
            begin bad++; $display("FAIL to_resp got=%b/%h exp=1/0", m1_read_response, m1_read_data); end
        total++; if (m1_write_response !== 1'b0) begin bad++; $display("FAIL to_wresp got=%b exp=0", m1_write_response); end
        tick();
        m1_read_request = 1'b0;
        s_read_response = 1'b1;
        s_read_data     = 32'h77;
        #1;
        total++; if (bus_error !== 1'b1) begin bad++; $display("FAIL to_bus_error got=%b exp=1", bus_error); end
        total++; if (m1_read_response !== 1'b0) begin bad++; $display("FAIL to_late_ignored got=%b exp=0", m1_read_response); end
        tick();
        clear_inputs();
        tick();
        tick();
        #1;
        total++; if (bus_error !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", bus_error); end
        do_reset();
        #1;
        total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL to_cleared got=%b exp=0", bus_error); end
    endtask
`else
    task automatic test_unbounded_wait();
        do_reset();
        m1_rw_address   = 5'h18;
        m1_read_request = 1'b1;
        tick();
        tick();
        for (int k = 0; k < TO + 5; k++) begin
            #1;
            total++; if (m1_read_response !== 1'b0 || bus_error !== 1'b0)
                begin bad++; $display("FAIL wait%0d got=%b/%b exp=0/0", k, m1_read_response, bus_error); end
            tick();
        end
        s_read_response = 1'b1;
        s_read_data     = 32'h55;
        #1;
        total++; if (m1_read_response !== 1'b1 || m1_read_data !== 32'h55)
            begin bad++; $display("FAIL wait_fwd got=%b/%h exp=1/55", m1_read_response, m1_read_data); end
        tick();
        clear_inputs();
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_read_write_both();
        test_late_response();
        test_reset_mid();
`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_unbounded_wait();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
